alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter W, default 16, the datapath width of x, y and result.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-004 SHALL have ports req0_valid / req1_valid, input, 1, requester operation valid.
REQ-005 SHALL have ports req0_ready / req1_ready, output, 1, requester operation accepted this cycle.
REQ-006 SHALL have ports req0_x, req0_y, req1_x, req1_y, input, W, signed operands.
REQ-007 SHALL have ports req0_ctrl / req1_ctrl, input, 6, control bits {zx,nx,zy,ny,f,no}, MSB = zx.
REQ-008 SHALL have port rsp_valid, output, 1, result valid.
REQ-009 SHALL have port rsp_ready, input, 1, consumer accepts result.
REQ-010 SHALL have port rsp_id, output, 1, index of the requester that owns the result.
REQ-011 SHALL have ports rsp_out (output, W, signed result), rsp_zr (output, 1, out==0) and rsp_ng (output, 1, out<0).
REQ-012 SHALL have port op_count, output, 16, number of completed responses.

Function
REQ-013 SHALL implement FSM states IDLE, EXEC and RESP.
REQ-014 In IDLE, the block SHALL select a requester when any reqN_valid=1: if only one is valid, that one; if both are valid, the one not equal to last_grant.
REQ-015 reqN_ready SHALL be combinational, high only in IDLE for the selected requester, and low for the other requester and in all other states.
REQ-016 A handshake SHALL occur when reqN_valid and reqN_ready are both high; on it, x, y, ctrl and id SHALL be latched into operand registers, last_grant set to N, and the state moved to EXEC.
REQ-017 In EXEC, the shared alu instance SHALL compute from the latched operands; out, zr and ng SHALL be registered into rsp_* with rsp_valid=1; next state RESP.
REQ-018 ALU semantics SHALL be, in order: zx zeroes x; nx inverts x; zy zeroes y; ny inverts y; f selects x+y (mod 2^W) or x&y; no inverts the result; zr = (out==0); ng = out[W-1].
REQ-019 In RESP, rsp_* SHALL hold stable until rsp_ready=1; on acceptance, op_count increments (wrapping 0xFFFF to 0), rsp_valid clears, and the state returns to IDLE.
REQ-020 Latency SHALL be as follows: request handshake at edge N gives rsp_valid=1 after edge N+1; minimum issue interval 3 cycles.
REQ-021 reqN_valid deasserting while not granted SHALL have no effect; requests SHALL never be dropped once accepted.
REQ-022 Operand changes after the handshake SHALL NOT affect the pending result.
REQ-023 With rsp_ready held low, the block SHALL stall in RESP indefinitely with both reqN_ready=0.

Reset
REQ-024 When rst=1 at a clock edge, state SHALL become IDLE, rsp_valid=0, rsp_id=0, rsp_out=0, rsp_zr=0, rsp_ng=0, op_count=0, and last_grant=1 (so req0 wins the first tie).
REQ-025 Reset in EXEC or RESP SHALL discard the in-flight operation without incrementing op_count; reset SHALL dominate all other inputs.

Structure
REQ-026 Package alu_pkg SHALL hold the ctrl bit-field typedef, the FSM state enum, the width constant, and named ctrl constants (ADD=000010, SUB_XY=010011, ZERO=101010, ONE=111111, AND=000000).
REQ-027 The existing combinational alu module SHALL be instantiated once as the shared resource; there SHALL be no other sub-module.

Verification
REQ-028 Scenario: reset, then req0 x=5, y=-7, ctrl=ADD, rsp_ready=1 -> rsp_out=-2 (0xFFFE), zr=0, ng=1, id=0, with rsp_valid 2 cycles after the handshake; op_count=1.
REQ-029 Scenario: req0 and req1 valid together, req0 SUB_XY x=9 y=9, req1 ONE -> req0 granted first (out=0, zr=1, ng=0), then req1 (out=1, zr=0, ng=0); op_count=2.
REQ-030 Scenario: both requesters continuously valid for 6 operations -> grants alternate 0,1,0,1,0,1 and no requester is starved.
REQ-031 Scenario: rsp_ready=0 for 10 cycles after the result -> rsp_* stable, both reqN_ready=0; when rsp_ready=1 for 1 cycle, the next grant follows in IDLE.
REQ-032 Scenario: rst asserted in RESP -> next cycle rsp_valid=0 and op_count unchanged from its pre-reset-zero value (0); a subsequent tie grants req0.
REQ-033 Scenario: 10000 random operations checked against a reference model of REQ-018 -> zero mismatches; op_count equals 10000 mod 65536.

Source files
------------

// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the arbitrated ALU: datapath width, the six-bit ALU
// control word, the arbiter FSM states and named control encodings.
// -----------------------------------------------------------------------------
package alu_pkg;

   localparam int unsigned ALU_W = 16;

   // Control word, MSB first: {zx, nx, zy, ny, f, no}.
   typedef struct packed {
      logic zx;   // zero x
      logic nx;   // invert x
      logic zy;   // zero y
      logic ny;   // invert y
      logic f;    // 1: x+y, 0: x&y
      logic no;   // invert result
   } alu_ctrl_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } arb_state_e;

   localparam alu_ctrl_t CTRL_ADD    = 6'b000010;
   localparam alu_ctrl_t CTRL_SUB_XY = 6'b010011;
   localparam alu_ctrl_t CTRL_ZERO   = 6'b101010;
   localparam alu_ctrl_t CTRL_ONE    = 6'b111111;
   localparam alu_ctrl_t CTRL_AND    = 6'b000000;

endpackage : alu_pkg

// File: rtl/alu.sv
// -----------------------------------------------------------------------------
// alu
// Purely combinational ALU shared by both requesters of alu_arbiter.
//   x_i, y_i : operands (W bits, two's complement)
//   ctrl_i   : control word {zx,nx,zy,ny,f,no}
//   out_o    : result
//   zr_o     : result is zero
//   ng_o     : result is negative (sign bit)
// -----------------------------------------------------------------------------
module alu
   import alu_pkg::*;
#(
   parameter int W = ALU_W
) (
   input  logic [W-1:0] x_i,
   input  logic [W-1:0] y_i,
   input  alu_ctrl_t    ctrl_i,
   output logic [W-1:0] out_o,
   output logic         zr_o,
   output logic         ng_o
);

   logic [W-1:0] x_z, x_n;
   logic [W-1:0] y_z, y_n;
   logic [W-1:0] f_res;

   // Operand conditioning is applied zero-then-invert, so zx+nx yields all ones.
   assign x_z   = ctrl_i.zx ? '0 : x_i;
   assign x_n   = ctrl_i.nx ? ~x_z : x_z;
   assign y_z   = ctrl_i.zy ? '0 : y_i;
   assign y_n   = ctrl_i.ny ? ~y_z : y_z;

   // Addition wraps modulo 2^W; the carry out is intentionally dropped.
   assign f_res = ctrl_i.f ? (x_n + y_n) : (x_n & y_n);
   assign out_o = ctrl_i.no ? ~f_res : f_res;

   assign zr_o  = (out_o == '0);
   assign ng_o  = out_o[W-1];

endmodule : alu

// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
// Two requesters share one combinational ALU. A request is accepted in IDLE,
// computed in EXEC and its registered result is held in RESP until consumed.
// Ties are broken round-robin against the last granted requester.
//   clk, rst                : clock, synchronous active-high reset
//   reqN_valid / reqN_ready : request handshake for requester N (ready is comb)
//   reqN_x, reqN_y          : signed operands
//   reqN_ctrl               : ALU control {zx,nx,zy,ny,f,no}
//   rsp_valid / rsp_ready   : response handshake
//   rsp_id                  : requester that owns the response
//   rsp_out, rsp_zr, rsp_ng : result and its zero / negative flags
//   op_count                : completed responses, wraps at 16 bits
// -----------------------------------------------------------------------------
module alu_arbiter
   import alu_pkg::*;
#(
   parameter int W = ALU_W
) (
   input  logic                clk,
   input  logic                rst,

   input  logic                req0_valid,
   output logic                req0_ready,
   input  logic signed [W-1:0] req0_x,
   input  logic signed [W-1:0] req0_y,
   input  logic [5:0]          req0_ctrl,

   input  logic                req1_valid,
   output logic                req1_ready,
   input  logic signed [W-1:0] req1_x,
   input  logic signed [W-1:0] req1_y,
   input  logic [5:0]          req1_ctrl,

   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic                rsp_id,
   output logic signed [W-1:0] rsp_out,
   output logic                rsp_zr,
   output logic                rsp_ng,
   output logic [15:0]         op_count
);

   arb_state_e   state_q, state_d;

   logic         last_grant_q, last_grant_d;
   logic         sel;
   logic         hs;

   logic [W-1:0] op_x_q, op_x_d;
   logic [W-1:0] op_y_q, op_y_d;
   alu_ctrl_t    op_ctrl_q, op_ctrl_d;
   logic         op_id_q, op_id_d;

   logic         rsp_valid_q, rsp_valid_d;
   logic         rsp_id_q, rsp_id_d;
   logic [W-1:0] rsp_out_q, rsp_out_d;
   logic         rsp_zr_q, rsp_zr_d;
   logic         rsp_ng_q, rsp_ng_d;
   logic [15:0]  op_count_q, op_count_d;

   logic [W-1:0] alu_out;
   logic         alu_zr;
   logic         alu_ng;

   // ---------------------------------------------------------------- arbiter
   // A lone requester wins outright; on a tie the one not granted last wins.
   always_comb begin
      sel = req1_valid;
      if (req0_valid && req1_valid) begin
         sel = ~last_grant_q;
      end
   end

   assign hs = (state_q == IDLE) && (req0_valid || req1_valid);

   // ---------------------------------------------------------- state register
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking <= so every register samples
      // pre-edge values regardless of process ordering.
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // -------------------------------------------------------------- next state
   always_comb begin
      // NOTE: default assignment first so no path leaves state_d unassigned,
      // which would otherwise infer a latch.
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (req0_valid || req1_valid) state_d = EXEC;
         EXEC:    state_d = RESP;
         RESP:    if (rsp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // ------------------------------------------------------------- FSM outputs
   always_comb begin
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      if (state_q == IDLE) begin
         req0_ready = req0_valid && !sel;
         req1_ready = req1_valid &&  sel;
      end
   end

   // ------------------------------------------------------ datapath next-state
   always_comb begin
      last_grant_d = last_grant_q;
      op_x_d       = op_x_q;
      op_y_d       = op_y_q;
      op_ctrl_d    = op_ctrl_q;
      op_id_d      = op_id_q;
      rsp_valid_d  = rsp_valid_q;
      rsp_id_d     = rsp_id_q;
      rsp_out_d    = rsp_out_q;
      rsp_zr_d     = rsp_zr_q;
      rsp_ng_d     = rsp_ng_q;
      op_count_d   = op_count_q;

      // Operands are captured at the handshake so later input changes cannot
      // disturb the pending result.
      if (hs) begin
         if (sel) begin
            op_x_d    = req1_x;
            op_y_d    = req1_y;
            op_ctrl_d = alu_ctrl_t'(req1_ctrl);
         end else begin
            op_x_d    = req0_x;
            op_y_d    = req0_y;
            op_ctrl_d = alu_ctrl_t'(req0_ctrl);
         end
         op_id_d      = sel;
         last_grant_d = sel;
      end

      if (state_q == EXEC) begin
         rsp_valid_d = 1'b1;
         rsp_id_d    = op_id_q;
         rsp_out_d   = alu_out;
         rsp_zr_d    = alu_zr;
         rsp_ng_d    = alu_ng;
      end

      // Result fields stay put after acceptance; only valid drops.
      if ((state_q == RESP) && rsp_ready) begin
         rsp_valid_d = 1'b0;
         op_count_d  = op_count_q + 16'd1;
      end
   end

   // --------------------------------------------------- control / response regs
   always_ff @(posedge clk) begin
      if (rst) begin
         last_grant_q <= 1'b1;
         rsp_valid_q  <= 1'b0;
         rsp_id_q     <= 1'b0;
         rsp_out_q    <= '0;
         rsp_zr_q     <= 1'b0;
         rsp_ng_q     <= 1'b0;
         op_count_q   <= 16'd0;
      end else begin
         last_grant_q <= last_grant_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_id_q     <= rsp_id_d;
         rsp_out_q    <= rsp_out_d;
         rsp_zr_q     <= rsp_zr_d;
         rsp_ng_q     <= rsp_ng_d;
         op_count_q   <= op_count_d;
      end
   end

   // ----------------------------------------------------------- operand regs
   // NOTE: operand registers carry no reset; they are always written at the
   // handshake before EXEC consumes them, so their power-up value is never seen.
   always_ff @(posedge clk) begin
      op_x_q    <= op_x_d;
      op_y_q    <= op_y_d;
      op_ctrl_q <= op_ctrl_d;
      op_id_q   <= op_id_d;
   end

   // ------------------------------------------------------------- shared ALU
   alu #(
      .W (W)
   ) u_alu (
      .x_i    (op_x_q),
      .y_i    (op_y_q),
      .ctrl_i (op_ctrl_q),
      .out_o  (alu_out),
      .zr_o   (alu_zr),
      .ng_o   (alu_ng)
   );

   assign rsp_valid = rsp_valid_q;
   assign rsp_id    = rsp_id_q;
   assign rsp_out   = rsp_out_q;
   assign rsp_zr    = rsp_zr_q;
   assign rsp_ng    = rsp_ng_q;
   assign op_count  = op_count_q;

endmodule : alu_arbiter

// File: tb/tb_alu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_arbiter
// Scoreboard bench for alu_arbiter. Per-requester op queues feed the request
// ports; on each grant the expected response is pushed to the scoreboard and a
// free-running monitor pops and compares whenever a response is consumed.
// -----------------------------------------------------------------------------
module tb_alu_arbiter;
   import alu_pkg::*;

   localparam int W = ALU_W;

   logic          clk = 1'b0;
   logic          rst;
   logic          req0_valid, req1_valid;
   logic          req0_ready, req1_ready;
   logic [W-1:0]  req0_x, req0_y, req1_x, req1_y;
   logic [5:0]    req0_ctrl, req1_ctrl;
   logic          rsp_valid, rsp_ready, rsp_id;
   logic [W-1:0]  rsp_out;
   logic          rsp_zr, rsp_ng;
   logic [15:0]   op_count;

   alu_arbiter #(.W(W)) dut (
      .clk        (clk),
      .rst        (rst),
      .req0_valid (req0_valid),
      .req0_ready (req0_ready),
      .req0_x     (req0_x),
      .req0_y     (req0_y),
      .req0_ctrl  (req0_ctrl),
      .req1_valid (req1_valid),
      .req1_ready (req1_ready),
      .req1_x     (req1_x),
      .req1_y     (req1_y),
      .req1_ctrl  (req1_ctrl),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_id     (rsp_id),
      .rsp_out    (rsp_out),
      .rsp_zr     (rsp_zr),
      .rsp_ng     (rsp_ng),
      .op_count   (op_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] x, y;
      logic [5:0]   ctrl;
      logic [W-1:0] out;
      logic         zr, ng;
   } op_t;

   typedef struct {
      logic         id;
      logic [W-1:0] out;
      logic         zr, ng;
      int           rise_cyc;
   } exp_t;

   op_t  q0[$], q1[$];
   exp_t sb[$];

   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;
   logic last_m = 1'b1;
   logic rand_rdy = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic op_t hand(input logic [W-1:0] x, input logic [W-1:0] y,
                                input logic [5:0] c, input logic [W-1:0] out,
                                input logic zr, input logic ng);
      op_t o;
      o.x = x; o.y = y; o.ctrl = c; o.out = out; o.zr = zr; o.ng = ng;
      return o;
   endfunction

   // Reference ALU for the random phase.
   function automatic op_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic [5:0] c);
      logic [W-1:0] a, b, r;
      a = c[5] ? '0 : x;
      if (c[4]) a = ~a;
      b = c[3] ? '0 : y;
      if (c[2]) b = ~b;
      r = c[1] ? (a + b) : (a & b);
      if (c[0]) r = ~r;
      return hand(x, y, c, r, (r == '0), r[W-1]);
   endfunction

   // Present the head of each queue; idle requesters get garbage operands.
   task automatic apply();
      req0_valid = (q0.size() != 0);
      req1_valid = (q1.size() != 0);
      if (q0.size() != 0) begin
         req0_x = q0[0].x; req0_y = q0[0].y; req0_ctrl = q0[0].ctrl;
      end else begin
         req0_x = W'($urandom); req0_y = W'($urandom); req0_ctrl = 6'($urandom);
      end
      if (q1.size() != 0) begin
         req1_x = q1[0].x; req1_y = q1[0].y; req1_ctrl = q1[0].ctrl;
      end else begin
         req1_x = W'($urandom); req1_y = W'($urandom); req1_ctrl = 6'($urandom);
      end
   endtask

   // Issue everything queued, predicting each grant from the round-robin model.
   task automatic serve();
      int idle;
      idle = 0;
      apply();
      while ((q0.size() != 0 || q1.size() != 0) && idle < 200) begin
         @(negedge clk);
         if (req0_ready || req1_ready) begin
            logic w;
            op_t  o;
            exp_t e;
            w = (q0.size() != 0 && q1.size() != 0) ? ~last_m : (q1.size() != 0);
            check("grant", {30'd0, req1_ready, req0_ready}, w ? 32'd2 : 32'd1);
            o = w ? q1[0] : q0[0];
            e.id = w; e.out = o.out; e.zr = o.zr; e.ng = o.ng;
            e.rise_cyc = cyc + 2;
            sb.push_back(e);
            last_m = w;
            @(posedge clk); #1;
            if (w) void'(q1.pop_front());
            else   void'(q0.pop_front());
            idle = 0;
            apply();
         end else begin
            idle++;
            @(posedge clk); #1;
         end
      end
      if (idle >= 200) check("grant_timeout", 32'd1, 32'd0);
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 500) begin
         @(negedge clk);
         n++;
      end
      if (n >= 500) check("drain_timeout", 32'd1, 32'd0);
   endtask

   task automatic wait_valid();
      int n;
      n = 0;
      @(negedge clk);
      while (!rsp_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) check("valid_timeout", 32'd1, 32'd0);
   endtask

   task automatic check_count(input logic [15:0] exp);
      @(posedge clk);
      @(negedge clk);
      check("op_count", {16'd0, op_count}, {16'd0, exp});
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst = 1'b1;
      q0.delete(); q1.delete(); sb.delete();
      apply();
      @(posedge clk); #1;
      rst = 1'b0;
      last_m = 1'b1;
   endtask

   // Monitor: latency on each new response, field compare on each acceptance.
   initial begin
      logic prev;
      exp_t e;
      prev = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev = 1'b0;
         end else begin
            if (rsp_valid && !prev && sb.size() != 0)
               check("latency", cyc, sb[0].rise_cyc);
            if (rsp_valid && rsp_ready) begin
               if (sb.size() == 0) begin
                  check("unexpected_rsp", 32'd1, 32'd0);
               end else begin
                  e = sb.pop_front();
                  check("rsp_id",  {31'd0, rsp_id}, {31'd0, e.id});
                  check("rsp_out", {16'd0, rsp_out}, {16'd0, e.out});
                  check("rsp_zr",  {31'd0, rsp_zr}, {31'd0, e.zr});
                  check("rsp_ng",  {31'd0, rsp_ng}, {31'd0, e.ng});
               end
            end
            prev = rsp_valid;
         end
      end
   end

   // Random consumer back-pressure during the random phase.
   initial begin
      forever begin
         @(posedge clk); #1;
         if (rand_rdy) rsp_ready = ($urandom_range(0, 3) != 0);
      end
   end

   initial begin
      #800000;
      $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n_ops;
      rst = 1'b1;
      rsp_ready = 1'b0;
      apply();
      do_reset();

      // Reset state.
      @(negedge clk);
      check("rst_valid",  {31'd0, rsp_valid}, 32'd0);
      check("rst_id",     {31'd0, rsp_id}, 32'd0);
      check("rst_out",    {16'd0, rsp_out}, 32'd0);
      check("rst_zr",     {31'd0, rsp_zr}, 32'd0);
      check("rst_ng",     {31'd0, rsp_ng}, 32'd0);
      check("rst_count",  {16'd0, op_count}, 32'd0);
      check("rst_ready",  {30'd0, req1_ready, req0_ready}, 32'd0);

      // Single ADD: 5 + -7 = -2.
      @(posedge clk); #1;
      rsp_ready = 1'b1;
      q0.push_back(hand(16'd5, 16'hFFF9, CTRL_ADD, 16'hFFFE, 1'b0, 1'b1));
      serve();
      wait_drain();
      check_count(16'd1);

      // Tie: req0 wins first (SUB 9-9=0), then req1 (ONE).
      do_reset();
      rsp_ready = 1'b1;
      q0.push_back(hand(16'd9, 16'd9, CTRL_SUB_XY, 16'h0000, 1'b1, 1'b0));
      q1.push_back(hand(16'h1234, 16'h5678, CTRL_ONE, 16'h0001, 1'b0, 1'b0));
      serve();
      wait_drain();
      check_count(16'd2);

      // Both continuously valid: grants must alternate 0,1,0,1,0,1.
      do_reset();
      rsp_ready = 1'b1;
      q0.push_back(hand(16'd100, 16'd23, CTRL_ADD, 16'h007B, 1'b0, 1'b0));
      q0.push_back(hand(16'hF0F0, 16'h3C3C, CTRL_AND, 16'h3030, 1'b0, 1'b0));
      q0.push_back(hand(16'hBEEF, 16'hCAFE, CTRL_ZERO, 16'h0000, 1'b1, 1'b0));
      q1.push_back(hand(16'd3, 16'd10, CTRL_SUB_XY, 16'hFFF9, 1'b0, 1'b1));
      q1.push_back(hand(16'h0042, 16'h0099, CTRL_ONE, 16'h0001, 1'b0, 1'b0));
      q1.push_back(hand(16'h7FFF, 16'h0001, CTRL_ADD, 16'h8000, 1'b0, 1'b1));
      serve();
      wait_drain();
      check_count(16'd6);

      // Stall in RESP for 10 cycles with req1 waiting.
      do_reset();
      rsp_ready = 1'b0;
      q0.push_back(hand(16'h0F0F, 16'h00FF, CTRL_AND, 16'h000F, 1'b0, 1'b0));
      serve();
      q1.push_back(hand(16'd2, 16'd3, CTRL_ADD, 16'h0005, 1'b0, 1'b0));
      apply();
      wait_valid();
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("stall_valid", {31'd0, rsp_valid}, 32'd1);
         check("stall_out",   {16'd0, rsp_out}, 32'h000F);
         check("stall_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
      end
      @(posedge clk); #1;
      rsp_ready = 1'b1;
      serve();
      wait_drain();
      check_count(16'd2);

      // Reset while holding a result in RESP.
      do_reset();
      rsp_ready = 1'b0;
      q0.push_back(hand(16'd1, 16'd1, CTRL_ADD, 16'h0002, 1'b0, 1'b0));
      serve();
      wait_valid();
      @(posedge clk); #1;
      rst = 1'b1;
      sb.delete();
      @(posedge clk); #1;
      rst = 1'b0;
      last_m = 1'b1;
      @(negedge clk);
      check("rstresp_valid", {31'd0, rsp_valid}, 32'd0);
      check("rstresp_count", {16'd0, op_count}, 32'd0);
      @(posedge clk); #1;
      rsp_ready = 1'b1;
      q0.push_back(hand(16'd7, 16'hFFF8, CTRL_ADD, 16'hFFFF, 1'b0, 1'b1));
      q1.push_back(hand(16'h5555, 16'hAAAA, CTRL_AND, 16'h0000, 1'b1, 1'b0));
      serve();
      wait_drain();
      check_count(16'd2);

      // Random operations against the reference model.
      do_reset();
      rand_rdy = 1'b1;
      n_ops = 0;
      while (n_ops < 10000) begin
         int pat;
         pat = (n_ops == 9999) ? int'($urandom_range(0, 1)) : int'($urandom_range(0, 2));
         if (pat != 1) begin
            q0.push_back(model(W'($urandom), W'($urandom), 6'($urandom)));
            n_ops++;
         end
         if (pat != 0) begin
            q1.push_back(model(W'($urandom), W'($urandom), 6'($urandom)));
            n_ops++;
         end
         serve();
      end
      wait_drain();
      check_count(16'(10000));
      rand_rdy = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_alu_arbiter
